// File: rtl/dma_tcb_loader.sv
// rtl/dma_tcb_loader.sv - fetches chained 6-word TCBs from internal memory and launches DMAC transfers
module dma_tcb_loader #(
    parameter int ADDR_SIZE = 16,
    parameter int DATA_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cp_wr,
    input  logic [ADDR_SIZE-1:0] cp_wdata,
    input  logic                 go,
    input  logic                 abort,
    input  logic                 stall_int,
    output logic                 mem_rd,
    output logic [ADDR_SIZE-1:0] mem_addr,
    input  logic [DATA_SIZE-1:0] mem_rd_data,
    output logic [ADDR_SIZE-1:0] dma_ii,
    output logic [ADDR_SIZE-1:0] dma_im,
    output logic [ADDR_SIZE-1:0] dma_ei,
    output logic [ADDR_SIZE-1:0] dma_em,
    output logic [DATA_SIZE-1:0] dma_c,
    output logic                 dma_start,
    input  logic                 dma_done,
    output logic                 busy,
    output logic                 chain_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_LAUNCH,
        S_RUN,
        S_NEXT
    } state_t;

    state_t               state, state_nxt;
    logic [ADDR_SIZE-1:0] cp;
    logic [2:0]           idx;
    logic                 rd_pend;
    logic [2:0]           rd_idx;
    logic [ADDR_SIZE-1:0] tcb_ii, tcb_im, tcb_ei, tcb_em, tcb_cp;
    logic [DATA_SIZE-1:0] tcb_c;
    logic [ADDR_SIZE-1:0] rd_as_addr;
    logic [ADDR_SIZE-1:0] idx_ext;

    // Memory words feeding address-sized TCB fields are truncated or zero-extended.
    generate
        if (ADDR_SIZE <= DATA_SIZE) begin : g_trunc
            assign rd_as_addr = mem_rd_data[ADDR_SIZE-1:0];
        end else begin : g_ext
            assign rd_as_addr = {{(ADDR_SIZE-DATA_SIZE){1'b0}}, mem_rd_data};
        end
    endgenerate

    assign idx_ext  = {{(ADDR_SIZE-3){1'b0}}, idx};
    assign mem_addr = (state == S_FETCH) ? cp + idx_ext : '0;
    assign busy     = (state != S_IDLE);
    assign dma_ii   = tcb_ii;
    assign dma_im   = tcb_im;
    assign dma_c    = tcb_c;
    assign dma_ei   = tcb_ei;
    assign dma_em   = tcb_em;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_rd     = 1'b0;
        dma_start  = 1'b0;
        chain_done = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go && !cp_wr) begin
                        state_nxt = S_FETCH;
                    end
                end
                S_FETCH: begin
                    mem_rd = !stall_int;
                    if (!stall_int && idx == 3'd5) begin
                        state_nxt = S_DRAIN;
                    end
                end
                // Word 2 (count) is always captured before the last read returns.
                S_DRAIN: begin
                    state_nxt = (tcb_c != '0) ? S_LAUNCH : S_NEXT;
                end
                S_LAUNCH: begin
                    dma_start = 1'b1;
                    state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (dma_done) begin
                        state_nxt = S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (tcb_cp == '0) begin
                        chain_done = 1'b1;
                        state_nxt  = S_IDLE;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cp      <= '0;
            idx     <= '0;
            rd_pend <= 1'b0;
            rd_idx  <= '0;
            tcb_ii  <= '0;
            tcb_im  <= '0;
            tcb_c   <= '0;
            tcb_ei  <= '0;
            tcb_em  <= '0;
            tcb_cp  <= '0;
        end else begin
            rd_pend <= mem_rd;
            rd_idx  <= idx;
            // Read data arrives one cycle after the strobe, independent of stall_int.
            if (rd_pend) begin
                case (rd_idx)
                    3'd0:    tcb_ii <= rd_as_addr;
                    3'd1:    tcb_im <= rd_as_addr;
                    3'd2:    tcb_c  <= mem_rd_data;
                    3'd3:    tcb_ei <= rd_as_addr;
                    3'd4:    tcb_em <= rd_as_addr;
                    3'd5:    tcb_cp <= rd_as_addr;
                    default: ;
                endcase
            end
            if (state == S_IDLE && !abort) begin
                if (cp_wr) begin
                    cp <= cp_wdata;
                end else if (go) begin
                    idx <= '0;
                end
            end
            if (mem_rd) begin
                idx <= idx + 3'd1;
            end
            if (state == S_NEXT && !abort && tcb_cp != '0) begin
                cp  <= tcb_cp;
                idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dma_tcb_loader.sv
// tb/tb_dma_tcb_loader.sv - directed self-checking bench for dma_tcb_loader
module tb_dma_tcb_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cp_wr = 1'b0;
    logic [15:0] cp_wdata = '0;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic        stall_int = 1'b0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_rd_data = '0;
    logic [15:0] dma_ii, dma_im, dma_ei, dma_em, dma_c;
    logic        dma_start;
    logic        dma_done = 1'b0;
    logic        busy;
    logic        chain_done;

    int          n_assert = 0;
    int          n_fail = 0;
    int          n_start = 0;
    int          n_done = 0;
    int          lat;
    int          s0, d0;
    logic [15:0] mem [0:65535];
    logic [15:0] rd_log [$];

    dma_tcb_loader #(.ADDR_SIZE(16), .DATA_SIZE(16)) dut (
        .clk(clk), .rst(rst), .cp_wr(cp_wr), .cp_wdata(cp_wdata), .go(go),
        .abort(abort), .stall_int(stall_int), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .dma_ii(dma_ii), .dma_im(dma_im), .dma_ei(dma_ei),
        .dma_em(dma_em), .dma_c(dma_c), .dma_start(dma_start), .dma_done(dma_done),
        .busy(busy), .chain_done(chain_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd === 1'b1) begin
            mem_rd_data <= mem[mem_addr];
            rd_log.push_back(mem_addr);
        end
        if (dma_start === 1'b1) n_start <= n_start + 1;
        if (chain_done === 1'b1) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_cp(input logic [15:0] v);
        cp_wr = 1'b1; cp_wdata = v;
        tick();
        cp_wr = 1'b0;
    endtask

    task automatic wait_start(input int budget, input int lat0, output int l);
        l = lat0;
        while (dma_start !== 1'b1 && l < budget) begin
            tick();
            l++;
        end
    endtask

    task automatic go_wait(output int l);
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_start(40, 1, l);
    endtask

    task automatic pulse_done();
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
    endtask

    task automatic set_tcb(input logic [15:0] a, input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] w4,
                           input logic [15:0] w5);
        mem[a] = w0; mem[16'(a+16'd1)] = w1; mem[16'(a+16'd2)] = w2;
        mem[16'(a+16'd3)] = w3; mem[16'(a+16'd4)] = w4; mem[16'(a+16'd5)] = w5;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [15:0] ea;
        set_tcb(16'h0010, 16'h0100, 16'h0001, 16'h0004, 16'h2000, 16'h0001, 16'h0000);
        set_tcb(16'h0020, 16'h0300, 16'h0002, 16'h0007, 16'h4000, 16'h0003, 16'h0000);
        set_tcb(16'h0030, 16'h0555, 16'h0001, 16'h0000, 16'h0666, 16'h0001, 16'h0000);
        set_tcb(16'hFFFE, 16'h0AAA, 16'h0001, 16'h0005, 16'h0BBB, 16'h0001, 16'h0000);
        mem[16'h0004] = 16'h0077; mem[16'h0005] = 16'h0000;

        // Reset state
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_dma_start", dma_start, 0);
        chk("rst_dma_ii", dma_ii, 0);
        chk("rst_dma_c", dma_c, 0);
        chk("rst_chain_done", chain_done, 0);
        rst = 1'b1;
        tick();

        // Single TCB
        load_cp(16'h0010);
        go_wait(lat);
        chk("t1_latency", lat, 8);
        chk("t1_ii", dma_ii, 16'h0100);
        chk("t1_im", dma_im, 16'h0001);
        chk("t1_c", dma_c, 16'h0004);
        chk("t1_ei", dma_ei, 16'h2000);
        chk("t1_em", dma_em, 16'h0001);
        cp_wr = 1'b1; cp_wdata = 16'h0050;
        tick();
        cp_wr = 1'b0;
        chk("t1_start_one_cycle", dma_start, 0);
        chk("t1_busy_run", busy, 1);
        pulse_done();
        chk("t1_chain_done", chain_done, 1);
        tick();
        chk("t1_chain_done_pulse", chain_done, 0);
        chk("t1_busy_idle", busy, 0);

        // Two-TCB chain; cp still 0x0010 since the cp_wr during RUN must be ignored
        mem[16'h0015] = 16'h0020;
        s0 = n_start; d0 = n_done;
        go_wait(lat);
        chk("t2_latency1", lat, 8);
        chk("t2_ii1", dma_ii, 16'h0100);
        tick();
        pulse_done();
        wait_start(40, 1, lat);
        chk("t2_latency2", lat, 9);
        chk("t2_ii2", dma_ii, 16'h0300);
        chk("t2_im2", dma_im, 16'h0002);
        chk("t2_c2", dma_c, 16'h0007);
        chk("t2_ei2", dma_ei, 16'h4000);
        chk("t2_em2", dma_em, 16'h0003);
        tick();
        pulse_done();
        chk("t2_chain_done", chain_done, 1);
        tick();
        chk("t2_start_count", n_start - s0, 2);
        chk("t2_done_count", n_done - d0, 1);
        mem[16'h0015] = 16'h0000;

        // Stall for three cycles during FETCH
        load_cp(16'h0010);
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        stall_int = 1'b1;
        #1 chk("t3_stall_rd_a", mem_rd, 0);
        tick();
        chk("t3_stall_rd_b", mem_rd, 0);
        tick();
        chk("t3_stall_rd_c", mem_rd, 0);
        tick();
        stall_int = 1'b0;
        #1 chk("t3_resume_rd", mem_rd, 1);
        chk("t3_resume_addr", mem_addr, 16'h0011);
        wait_start(40, 5, lat);
        chk("t3_latency", lat, 11);
        chk("t3_ii", dma_ii, 16'h0100);
        chk("t3_c", dma_c, 16'h0004);
        chk("t3_ei", dma_ei, 16'h2000);
        tick();
        pulse_done();
        chk("t3_chain_done", chain_done, 1);
        tick();

        // C=0, CP=0: no launch
        s0 = n_start;
        load_cp(16'h0030);
        go = 1'b1;
        tick();
        go = 1'b0;
        lat = 1;
        while (chain_done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk("t4_done_latency", lat, 8);
        chk("t4_c", dma_c, 0);
        chk("t4_ii", dma_ii, 16'h0555);
        tick();
        chk("t4_no_start", n_start - s0, 0);
        chk("t4_busy", busy, 0);

        // Address wrap, then abort during RUN with simultaneous dma_done
        load_cp(16'hFFFE);
        rd_log.delete();
        go_wait(lat);
        chk("t5_latency", lat, 8);
        chk("t5_nreads", rd_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            ea = 16'hFFFE + 16'(i);
            if (i < rd_log.size()) chk("t5_wrap_addr", rd_log[i], ea);
        end
        chk("t5_c", dma_c, 16'h0005);
        tick();
        d0 = n_done;
        abort = 1'b1; dma_done = 1'b1;
        tick();
        abort = 1'b0; dma_done = 1'b0;
        chk("t5_abort_idle", busy, 0);
        chk("t5_abort_no_done", chain_done, 0);
        pulse_done();
        chk("t5_late_done_busy", busy, 0);
        tick();
        chk("t5_late_done_count", n_done - d0, 0);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("t5_cp_kept", mem_addr, 16'hFFFE);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_fetch_busy", busy, 0);
        chk("t5_abort_fetch_rd", mem_rd, 0);
        tick();

        // Asynchronous reset mid-FETCH
        go = 1'b1;
        tick();
        go = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1 chk("t6_rst_busy", busy, 0);
        chk("t6_rst_mem_rd", mem_rd, 0);
        chk("t6_rst_mem_addr", mem_addr, 0);
        chk("t6_rst_ii", dma_ii, 0);
        chk("t6_rst_c", dma_c, 0);
        tick();
        rst = 1'b1;
        s0 = n_start;
        repeat (10) tick();
        chk("t6_no_start", n_start - s0, 0);
        chk("t6_idle", busy, 0);
        go_wait(lat);
        chk("t6_latency", lat, 8);
        chk("t6_ii", dma_ii, 16'h0005);
        chk("t6_im", dma_im, 16'h0BBB);
        chk("t6_c", dma_c, 16'h0001);
        chk("t6_em", dma_em, 16'h0077);
        tick();
        pulse_done();
        chk("t6_chain_done", chain_done, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
